// File: rtl/uart_rx_os_if.sv
// Consumer-side handshake bundle for the oversampling UART receiver.
// The receiver owns the slave modport; the consumer of received bytes owns master.
interface uart_rx_os_if;
    logic       i_ack;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    modport master (
        output i_ack,
        input  o_data, o_valid, o_frame_err, o_overrun, o_busy
    );

    modport slave (
        input  i_ack,
        output o_data, o_valid, o_frame_err, o_overrun, o_busy
    );
endinterface

// File: rtl/uart_rx_os.sv
// 8N1 oversampling UART receiver: two-flop synchroniser, mid-bit sampling FSM,
// and a holding register with valid/ack handshake plus frame-error and overrun pulses.
module uart_rx_os #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rxd,
    uart_rx_os_if.slave     bus
);

    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             sync1, rxd_s;
    logic             load_c, ferr_c;
    logic             load_pend, ferr_pend;

    // Synchroniser, state and bit-timing registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            sync1   <= 1'b1;
            rxd_s   <= 1'b1;
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            sync1   <= i_rxd;
            rxd_s   <= sync1;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    // Next-state and sample strobes; load_c/ferr_c fire on the stop-bit sample.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        load_c      = 1'b0;
        ferr_c      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_nxt = S_START;
                    cnt_nxt   = '0;
                end
            end
            S_START: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == HALF_C) begin
                    cnt_nxt = '0;
                    if (rxd_s) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt   = S_DATA;
                        bit_idx_nxt = '0;
                    end
                end
            end
            S_DATA: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == FULL_C) begin
                    cnt_nxt            = '0;
                    shreg_nxt[bit_idx] = rxd_s;
                    bit_idx_nxt        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == FULL_C) begin
                    cnt_nxt = '0;
                    if (rxd_s) begin
                        state_nxt = S_IDLE;
                        load_c    = 1'b1;
                    end else begin
                        state_nxt = S_WAIT_IDLE;
                        ferr_c    = 1'b1;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (rxd_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output stage runs one edge behind the state register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            load_pend       <= 1'b0;
            ferr_pend       <= 1'b0;
            bus.o_data      <= 8'h00;
            bus.o_valid     <= 1'b0;
            bus.o_frame_err <= 1'b0;
            bus.o_overrun   <= 1'b0;
            bus.o_busy      <= 1'b0;
        end else begin
            load_pend       <= load_c;
            ferr_pend       <= ferr_c;
            bus.o_busy      <= (state != S_IDLE);
            bus.o_frame_err <= ferr_pend;
            bus.o_overrun   <= 1'b0;
            if (load_pend) begin
                // A load always wins over a simultaneous ack.
                bus.o_data    <= shreg;
                bus.o_valid   <= 1'b1;
                bus.o_overrun <= bus.o_valid & ~bus.i_ack;
            end else if (bus.o_valid && bus.i_ack) begin
                bus.o_valid <= 1'b0;
            end
        end
    end

endmodule
